ppu_vram_snoop: RTL and testbench
=================================

// Module: ppu_vram_snoop
// PURPOSE
//  Passive mirror of PPU video memory for save-state capture: decodes CPU writes to $2000/$2002/$2005-$2007,
//  tracks the PPU address latch and increment mode, and copies every $2007 write into a shadow nametable
//  (2 KB) and palette (32 B). The OS reads the shadow back through a 4-register window at $4108-$410B.
//  This is the write-capture side of the system VRAM path; it sits beside the system mapper on the CPU bus.
// PARAMETERS
//  REG_BASE  8'h08  low byte of the readback window in page $41xx (4 consecutive registers)
//  NTB_AW    11     shadow nametable address width (2 KB = two CIRAM pages)
//  PAL_AW    5      shadow palette address width
// PORTS
//  clk       in   1   system clock (50 MHz); sole clock of the block
//  sys_rst   in   1   asynchronous, active-high reset
//  m2        in   1   CPU phase-2 strobe, asynchronous to clk
//  cpu_addr  in   16  CPU address bus
//  cpu_dat   in   8   CPU data bus (write data)
//  cpu_rw    in   1   1 = read, 0 = write
//  os_act    in   1   OS active; readback window decodes only when high
//  snoop_en  in   1   1 = capture $2007 writes; 0 = latch/toggle tracking continues, RAM writes suppressed
//  mir_h     in   1   1 = horizontal mirroring (CIRAM A10 = PPU A11), 0 = vertical (A10 = PPU A10)
//  rb_dout   out  8   readback register data, valid whenever the window is decoded and m2 = 1
//  rb_oe     out  1   1 = drive rb_dout onto CPU bus (window decoded, cpu_rw = 1, m2 = 1)
// BEHAVIOUR
//  Bus sampling:
//  - m2 goes through a 2-flop synchroniser.
//  - While synced m2 = 1, cpu_addr, cpu_dat and cpu_rw are registered each clk.
//  - A CPU cycle event (EV) fires on the clk where synced m2 goes 1 -> 0 and uses the registered copy.
//    One EV per CPU cycle.
//  PPU register decode, on EV with cpu_addr[15:13] = 3'b001, reg = addr[2:0]:
//  - W $2000: inc32 <= dat[2].
//  - R $2002: toggle <= 0.
//  - W $2005: toggle <= !toggle.
//  - W $2006, toggle = 0: t_hi <= dat[5:0], toggle <= 1.
//  - W $2006, toggle = 1: v <= {t_hi, dat}, toggle <= 0.
//  - W $2007, snoop_en = 1:
//    - v[13:8] = 6'h3F: write pal[v[4:0]]; indices $10/$14/$18/$1C fold to $00/$04/$08/$0C.
//    - else v[13] = 1: write ntb[{a10, v[9:0]}], where a10 = mir_h ? v[11] : v[10].
//    - else (CHR space): no write.
//  - R or W $2007: v <= (v + (inc32 ? 32 : 1)) mod 2^14, wrapping $3FFF -> $0000. Applies regardless of snoop_en.
//  Readback window, decoded when os_act = 1 and cpu_addr = $4100 + REG_BASE + n:
//  - n = 0: W rb_addr[7:0]. R returns rb_addr[7:0].
//  - n = 1: W rb_addr[11:8]. R returns {4'h0, rb_addr[11:8]}.
//  - n = 2: R returns the prefetched byte; on EV, rb_addr <= rb_addr + 1 (12-bit wrap). Writes ignored.
//  - n = 3: R returns status {toggle, inc32, v[13:8]}. Writes ignored.
//  Readback data map:
//  - rb_addr $000-$7FF: ntb.
//  - $800-$81F: pal.
//  - all other addresses: 8'h00.
//  Prefetch:
//  - On any rb_addr change, a synchronous RAM read is issued.
//  - The result is registered into rb_data <= 2 clk after the EV, i.e. well inside the next m2-high phase.
//  - rb_data is a snapshot and is not refreshed by later snoop writes to the same location.
//  RAM ports:
//  - ntb is dual-port: port A = snoop write, port B = prefetch read.
//  - A same-clk read/write to one address returns old data.
//  Reset values (all outputs and state): rb_dout = 0, rb_oe = 0, rb_data = 0, toggle = 0, inc32 = 0,
//  t_hi = 0, v = 0, rb_addr = 0, m2 synchroniser = 0.
//  - RAM contents are not cleared by reset.
//  - Reset mid-cycle aborts any pending EV; no partial RAM write.
//  Simultaneous events: snoop writes and readback accesses are separate CPU cycles and never coincide.
//  Prefetch vs snoop on the same clk is covered by the port rule above.
// STRUCTURE
//  - Register offsets, PPU register indices and palette-fold mask are constants in defs.v.
//  - ntb reuses the existing ram_dp sub-module. pal is a 32x8 register array in this module.
//  - A small m2 edge-detect helper (m2_evt_sync) is natural as a separate sub-module for reuse.
// TESTING
//  1. W $2006 = $20, W $2006 = $45, W $2007 = $AB, mir_h = 0 -> ntb[$045] = $AB, v = $2046.
//  2. W $2000 = $04, set v = $23C0, write $2007 x3 -> v = $2420; then R $2002, single W $2006 -> toggle = 1.
//  3. Set v = $3F10, W $2007 = $0F -> pal[$00] = $0F.
//     Then rb_addr = $800, R $410A -> $0F, and rb_addr = $801.
//  4. mir_h = 1, set v = $2C05, W $2007 = $77 -> ntb[$405] = $77.
//     Then set v = $3FFF, one $2007 read -> v = $0000, no RAM write.
//  5. snoop_en = 0, W $2007 = $11 at v = $2000 -> ntb unchanged, v = $2001.
//     os_act = 0 R $410A -> rb_oe = 0.
//  6. Assert sys_rst during m2 high of a $2007 write -> no RAM write.
//     After release: status R $410B = $00, rb_dout = $00.

Source files
------------

// File: rtl/ppu_vram_snoop_pkg.sv
// Shared constants for the PPU VRAM snoop block.
//   - PPU register indices (CPU address bits [2:0] inside $2000-$3FFF)
//   - readback window register offsets
//   - palette page and mirror-fold helper
package ppu_vram_snoop_pkg;

    localparam logic [2:0] PPU_CTRL   = 3'd0;
    localparam logic [2:0] PPU_STATUS = 3'd2;
    localparam logic [2:0] PPU_SCROLL = 3'd5;
    localparam logic [2:0] PPU_ADDR   = 3'd6;
    localparam logic [2:0] PPU_DATA   = 3'd7;

    localparam logic [1:0] RB_LO   = 2'd0;
    localparam logic [1:0] RB_HI   = 2'd1;
    localparam logic [1:0] RB_DATA = 2'd2;
    localparam logic [1:0] RB_STAT = 2'd3;

    localparam logic [5:0] PAL_PAGE      = 6'h3F;
    localparam logic [4:0] PAL_FOLD_MASK = 5'h0F;

    // Sprite backdrop entries $10/$14/$18/$1C alias the background ones.
    function automatic logic [4:0] pal_fold(input logic [4:0] idx);
        return (idx[4] && (idx[1:0] == 2'b00)) ? (idx & PAL_FOLD_MASK) : idx;
    endfunction

endpackage

// File: rtl/ppu_vram_snoop_m2_evt_sync.sv
// m2_evt_sync: brings the CPU m2 strobe into the clk domain and produces a
// single-clk event on the falling edge of every complete CPU cycle.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   m2     in  raw CPU phase-2 strobe
//   m2_hi  out synchronised m2 (bus capture enable)
//   ev     out one-clk pulse when synchronised m2 falls after a seen rise
module m2_evt_sync (
    input  logic clk,
    input  logic rst,
    input  logic m2,
    output logic m2_hi,
    output logic ev
);

    logic       m2_s1;
    logic       m2_s2;
    logic       m2_q;
    logic       armed;
    // Fills with ones after reset; m2_q only reflects real samples once
    // warm[2] is set, so a cycle already in progress at reset release is
    // never mistaken for a fresh rising edge.
    logic [2:0] warm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m2_s1 <= 1'b0;
            m2_s2 <= 1'b0;
            m2_q  <= 1'b0;
            armed <= 1'b0;
            warm  <= 3'b000;
        end else begin
            m2_s1 <= m2;
            m2_s2 <= m2_s1;
            m2_q  <= m2_s2;
            warm  <= {warm[1:0], 1'b1};
            if (warm[2] && m2_s2 && !m2_q)
                armed <= 1'b1;
            else if (ev)
                armed <= 1'b0;
        end
    end

    assign m2_hi = m2_s2;
    assign ev    = m2_q && !m2_s2 && armed;

endmodule

// File: rtl/ppu_vram_snoop_ram_dp.sv
// ram_dp: simple dual-port synchronous RAM, no reset on contents.
//   clk     in  clock
//   we_a    in  port A write enable
//   addr_a  in  port A write address
//   din_a   in  port A write data
//   addr_b  in  port B read address
//   dout_b  out port B registered read data (old data on same-clk collision)
module ram_dp #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] dout_b
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we_a)
            mem[addr_a] <= din_a;
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/ppu_vram_snoop.sv
// ppu_vram_snoop: passive shadow of PPU nametable/palette writes, with an
// OS readback window of four registers at $4100 + REG_BASE.
//   clk       in  system clock
//   sys_rst   in  asynchronous active-high reset
//   m2        in  CPU phase-2 strobe (async)
//   cpu_addr  in  CPU address bus
//   cpu_dat   in  CPU write data
//   cpu_rw    in  1 = read, 0 = write
//   os_act    in  enables the readback window
//   snoop_en  in  enables shadow RAM writes from $2007
//   mir_h     in  1 = horizontal mirroring
//   rb_dout   out readback data
//   rb_oe     out readback bus drive enable
module ppu_vram_snoop
    import ppu_vram_snoop_pkg::*;
#(
    parameter logic [7:0] REG_BASE = 8'h08,
    parameter int         NTB_AW   = 11,
    parameter int         PAL_AW   = 5
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        m2,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    input  logic        cpu_rw,
    input  logic        os_act,
    input  logic        snoop_en,
    input  logic        mir_h,
    output logic [7:0]  rb_dout,
    output logic        rb_oe
);

    localparam logic [15:0] WIN_BASE = {8'h41, REG_BASE};

    logic        m2_hi;
    logic        ev;

    logic [15:0] bus_addr;
    logic [7:0]  bus_dat;
    logic        bus_rw;
    logic        bus_os;

    logic        toggle;
    logic        inc32;
    logic [5:0]  t_hi;
    logic [13:0] v;
    logic [11:0] rb_addr;
    logic [7:0]  rb_data;

    logic        pf1;
    logic        pf2;
    logic        sel_ntb;
    logic        sel_pal;
    logic [7:0]  ntb_q;
    logic [7:0]  pal_q;
    logic [7:0]  pal [0:(1<<PAL_AW)-1];

    m2_evt_sync u_evt (
        .clk   (clk),
        .rst   (sys_rst),
        .m2    (m2),
        .m2_hi (m2_hi),
        .ev    (ev)
    );

    // Bus copy follows the CPU while m2 is high and freezes once it drops,
    // so the event clk sees the values of the cycle just finished.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus_addr <= 16'h0000;
            bus_dat  <= 8'h00;
            bus_rw   <= 1'b1;
            bus_os   <= 1'b0;
        end else if (m2_hi) begin
            bus_addr <= cpu_addr;
            bus_dat  <= cpu_dat;
            bus_rw   <= cpu_rw;
            bus_os   <= os_act;
        end
    end

    logic [15:0] rb_off_q;
    logic        rb_hit_q;
    logic        ppu_hit_q;
    logic        data_wr;
    logic        pal_we;
    logic        ntb_we;
    logic        rb_chg;
    logic [NTB_AW-1:0] ntb_wa;

    assign rb_off_q  = bus_addr - WIN_BASE;
    assign rb_hit_q  = bus_os && (rb_off_q[15:2] == 14'd0);
    assign ppu_hit_q = (bus_addr[15:13] == 3'b001);
    assign data_wr   = ev && ppu_hit_q && (bus_addr[2:0] == PPU_DATA) && !bus_rw && snoop_en;
    assign pal_we    = data_wr && (v[13:8] == PAL_PAGE);
    assign ntb_we    = data_wr && (v[13:8] != PAL_PAGE) && v[13];
    assign ntb_wa    = {(mir_h ? v[11] : v[10]), v[9:0]};

    assign rb_chg = ev && rb_hit_q &&
                    (((rb_off_q[1:0] == RB_LO || rb_off_q[1:0] == RB_HI) && !bus_rw) ||
                     ((rb_off_q[1:0] == RB_DATA) && bus_rw));

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            toggle  <= 1'b0;
            inc32   <= 1'b0;
            t_hi    <= 6'h00;
            v       <= 14'h0000;
            rb_addr <= 12'h000;
            rb_data <= 8'h00;
            pf1     <= 1'b0;
            pf2     <= 1'b0;
            sel_ntb <= 1'b0;
            sel_pal <= 1'b0;
        end else begin
            pf1     <= rb_chg;
            pf2     <= pf1;
            sel_ntb <= !rb_addr[11];
            sel_pal <= (rb_addr[11:5] == 7'h40);
            // Second clk after the address moved: RAM/palette outputs now
            // reflect the new rb_addr. Snapshot is taken only here.
            if (pf2)
                rb_data <= sel_ntb ? ntb_q : (sel_pal ? pal_q : 8'h00);

            if (ev && ppu_hit_q) begin
                case (bus_addr[2:0])
                    PPU_CTRL:   if (!bus_rw) inc32 <= bus_dat[2];
                    PPU_STATUS: if (bus_rw) toggle <= 1'b0;
                    PPU_SCROLL: if (!bus_rw) toggle <= !toggle;
                    PPU_ADDR: begin
                        if (!bus_rw) begin
                            if (!toggle) begin
                                t_hi   <= bus_dat[5:0];
                                toggle <= 1'b1;
                            end else begin
                                v      <= {t_hi, bus_dat};
                                toggle <= 1'b0;
                            end
                        end
                    end
                    PPU_DATA:   v <= v + (inc32 ? 14'd32 : 14'd1);
                    default: ;
                endcase
            end

            if (ev && rb_hit_q) begin
                case (rb_off_q[1:0])
                    RB_LO:   if (!bus_rw) rb_addr[7:0]  <= bus_dat;
                    RB_HI:   if (!bus_rw) rb_addr[11:8] <= bus_dat[3:0];
                    RB_DATA: if (bus_rw)  rb_addr       <= rb_addr + 12'd1;
                    default: ;
                endcase
            end
        end
    end

    ram_dp #(
        .AW (NTB_AW),
        .DW (8)
    ) u_ntb (
        .clk    (clk),
        .we_a   (ntb_we),
        .addr_a (ntb_wa),
        .din_a  (bus_dat),
        .addr_b (rb_addr[NTB_AW-1:0]),
        .dout_b (ntb_q)
    );

    // Palette storage has no reset: contents survive like the nametable.
    always_ff @(posedge clk) begin
        if (pal_we)
            pal[pal_fold(v[4:0])] <= bus_dat;
        pal_q <= pal[pal_fold(rb_addr[4:0])];
    end

    logic [15:0] live_off;
    logic        live_hit;

    assign live_off = cpu_addr - WIN_BASE;
    assign live_hit = os_act && (live_off[15:2] == 14'd0) && m2 && !sys_rst;
    assign rb_oe    = live_hit && cpu_rw;

    always_comb begin
        rb_dout = 8'h00;
        if (live_hit) begin
            case (live_off[1:0])
                RB_LO:   rb_dout = rb_addr[7:0];
                RB_HI:   rb_dout = {4'h0, rb_addr[11:8]};
                RB_DATA: rb_dout = rb_data;
                RB_STAT: rb_dout = {toggle, inc32, v[13:8]};
                default: rb_dout = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_vram_snoop.sv
module tb_ppu_vram_snoop;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        m2;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        cpu_rw;
    logic        os_act;
    logic        snoop_en;
    logic        mir_h;
    logic [7:0]  rb_dout;
    logic        rb_oe;

    ppu_vram_snoop dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .m2       (m2),
        .cpu_addr (cpu_addr),
        .cpu_dat  (cpu_dat),
        .cpu_rw   (cpu_rw),
        .os_act   (os_act),
        .snoop_en (snoop_en),
        .mir_h    (mir_h),
        .rb_dout  (rb_dout),
        .rb_oe    (rb_oe)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       nm;
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        logic        os;
        logic        sn;
        logic        mh;
        logic        chk;
        logic [7:0]  exp;
        logic        exp_oe;
        logic        rst_abort;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    logic cur_os = 1'b1;
    logic cur_sn = 1'b1;
    logic cur_mh = 1'b0;

    task automatic push(input string nm, input logic [15:0] a, input logic [7:0] d,
                        input logic rw, input logic chk, input logic [7:0] exp,
                        input logic exp_oe, input logic ra);
        vec_t e;
        e.nm = nm; e.a = a; e.d = d; e.rw = rw;
        e.os = cur_os; e.sn = cur_sn; e.mh = cur_mh;
        e.chk = chk; e.exp = exp; e.exp_oe = exp_oe; e.rst_abort = ra;
        vq.push_back(e);
    endtask

    task automatic w(input logic [15:0] a, input logic [7:0] d);
        push("", a, d, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic r(input logic [15:0] a);
        push("", a, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rc(input string nm, input logic [15:0] a, input logic [7:0] exp);
        push(nm, a, 8'h00, 1'b1, 1'b1, exp, 1'b1, 1'b0);
    endtask

    task automatic set_v(input logic [13:0] nv);
        logic [13:0] t;
        t = nv;
        w(16'h2006, {2'b00, t[13:8]});
        w(16'h2006, t[7:0]);
    endtask

    task automatic set_rb(input logic [11:0] ra);
        logic [11:0] t;
        t = ra;
        w(16'h4108, t[7:0]);
        w(16'h4109, {4'h0, t[11:8]});
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic rw,
                       output logic [7:0] dout, output logic oe);
        @(negedge clk);
        cpu_addr = a; cpu_dat = d; cpu_rw = rw; m2 = 1'b1;
        repeat (8) @(negedge clk);
        dout = rb_dout;
        oe   = rb_oe;
        @(negedge clk);
        m2 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // CPU cycle cut by a reset pulse while m2 is high; reset is released
    // with m2 still high so the tail of the cycle must be ignored.
    task automatic abort_cyc(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_dat = d; cpu_rw = 1'b0; m2 = 1'b1;
        repeat (4) @(negedge clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
        repeat (4) @(negedge clk);
        m2 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic act_oe,
                         input logic [7:0] exp, input logic exp_oe);
        checks++;
        if (act !== exp || act_oe !== exp_oe) begin
            errors++;
            $display("FAIL %s: got dout=%02h oe=%0b, want dout=%02h oe=%0b",
                     nm, act, act_oe, exp, exp_oe);
        end
    endtask

    initial begin
        logic [7:0] dout;
        logic       oe;

        // test 1: basic nametable capture, then v low bits via a second write
        rc("rst_status", 16'h410B, 8'h00);
        rc("rst_rbaddr", 16'h4108, 8'h00);
        set_v(14'h2045);
        w(16'h2007, 8'hAB);
        w(16'h2007, 8'hCD);
        rc("t1_status", 16'h410B, 8'h20);
        set_rb(12'h045);
        rc("t1_ntb045", 16'h410A, 8'hAB);
        rc("t1_v2046", 16'h410A, 8'hCD);

        // test 2: inc32 stepping and toggle handling
        w(16'h2000, 8'h04);
        set_v(14'h23C0);
        w(16'h2007, 8'h01);
        w(16'h2007, 8'h02);
        w(16'h2007, 8'h03);
        rc("t2_status_v2420", 16'h410B, 8'h64);
        w(16'h2007, 8'h5A);
        r(16'h2002);
        w(16'h2006, 8'h3F);
        rc("t2_toggle1", 16'h410B, 8'hE4);
        set_rb(12'h3E0);
        rc("t2_ntb3E0", 16'h410A, 8'h02);
        set_rb(12'h400);
        rc("t2_ntb400", 16'h410A, 8'h03);
        set_rb(12'h420);
        rc("t2_ntb420", 16'h410A, 8'h5A);

        // test 3: palette fold $3F10 -> pal[0], auto-increment of rb_addr
        w(16'h2000, 8'h00);
        w(16'h2006, 8'h10);
        w(16'h2007, 8'h0F);
        set_rb(12'h800);
        rc("t3_pal00", 16'h410A, 8'h0F);
        rc("t3_rb_lo", 16'h4108, 8'h01);
        rc("t3_rb_hi", 16'h4109, 8'h08);

        // test 4: mirroring select, then v wrap $3FFF -> $0000
        cur_mh = 1'b1;
        set_v(14'h2C05);
        w(16'h2007, 8'h77);
        set_v(14'h2806);
        w(16'h2007, 8'h66);
        cur_mh = 1'b0;
        set_v(14'h2407);
        w(16'h2007, 8'h55);
        set_rb(12'h405);
        rc("t4_ntb405", 16'h410A, 8'h77);
        rc("t4_ntb406_h", 16'h410A, 8'h66);
        rc("t4_ntb407_v", 16'h410A, 8'h55);
        set_v(14'h3FFF);
        rc("t4_v3fxx", 16'h410B, 8'h3F);
        r(16'h2007);
        rc("t4_wrap", 16'h410B, 8'h00);

        // test 5: snoop disabled suppresses RAM write but still steps v
        set_v(14'h2000);
        w(16'h2007, 8'h99);
        set_v(14'h2000);
        cur_sn = 1'b0;
        w(16'h2007, 8'h11);
        cur_sn = 1'b1;
        w(16'h2007, 8'h22);
        set_rb(12'h000);
        rc("t5_ntb000", 16'h410A, 8'h99);
        rc("t5_ntb001", 16'h410A, 8'h22);
        cur_os = 1'b0;
        push("t5_os_off", 16'h410A, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cur_os = 1'b1;

        // test 6: reset in the middle of a $2007 write and a $2005 write
        set_v(14'h2010);
        w(16'h2007, 8'h33);
        w(16'h2000, 8'h04);
        set_v(14'h2010);
        w(16'h2005, 8'h00);
        rc("t6_pre_status", 16'h410B, 8'hE0);
        push("", 16'h2007, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        rc("t6_status", 16'h410B, 8'h00);
        rc("t6_rbdata", 16'h410A, 8'h00);
        set_rb(12'h010);
        rc("t6_noram", 16'h410A, 8'h33);
        push("", 16'h2005, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        rc("t6_abort_toggle", 16'h410B, 8'h00);

        // reset state, including output gating while reset is held
        sys_rst  = 1'b1;
        m2       = 1'b1;
        cpu_addr = 16'h410B;
        cpu_dat  = 8'h00;
        cpu_rw   = 1'b1;
        os_act   = 1'b1;
        snoop_en = 1'b1;
        mir_h    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_held_out", rb_dout, rb_oe, 8'h00, 1'b0);
        m2 = 1'b0;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_idle_out", rb_dout, rb_oe, 8'h00, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            os_act   = vq[i].os;
            snoop_en = vq[i].sn;
            mir_h    = vq[i].mh;
            if (vq[i].rst_abort) begin
                abort_cyc(vq[i].a, vq[i].d);
            end else begin
                cyc(vq[i].a, vq[i].d, vq[i].rw, dout, oe);
                if (vq[i].chk)
                    check(vq[i].nm, dout, oe, vq[i].exp, vq[i].exp_oe);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
